ram_access_arbiter: RTL and testbench

- Shares the single-port RAM (registered read, one-cycle read latency) between two requesters.
  - Port A: core datapath (accumulator load/store path).
  - Port B: loader/DMA path.
- Grants at most one access per cycle.
- Enforces a bounded burst for fairness.
- Returns read data to the originating requester with a valid strobe aligned to RAM output.
- Sits directly in front of the RAM; the RAM's ports connect only to this block.

---
 rtl/ram_access_arbiter.sv | 79 +++++++
 tb/tb_ram_access_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM between port A (core) and port B (loader) with bounded-burst fairness
// Ports: Clock/Reset (async, active-low); per port P in {A,B}: iReqP/iWeP/iAddrP/iDataP in,
//   oGntP (accepted this cycle), oValidP/oDataP (read result one cycle after a read grant);
//   oRamWriteEnable/oRamAddress/oRamDataIn drive the RAM, iRamDataOut is its registered output;
//   oBusy flags a grant this cycle.
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReqA,
  input  logic                  iWeA,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iDataA,
  output logic                  oGntA,
  output logic                  oValidA,
  output logic [DATA_WIDTH-1:0] oDataA,
  input  logic                  iReqB,
  input  logic                  iWeB,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataB,
  output logic                  oGntB,
  output logic                  oValidB,
  output logic [DATA_WIDTH-1:0] oDataB,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  input  logic [DATA_WIDTH-1:0] iRamDataOut,
  output logic                  oBusy
);
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;
  own_t       owner_q, owner_d;
  logic       last_b_q, last_b_d;
  logic [3:0] burst_q, burst_d;
  logic       valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic       gnt_a, gnt_b;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      owner_q   <= OWN_NONE;
      last_b_q  <= 1'b1;
      burst_q   <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_b_q  <= last_b_d;
      burst_q   <= burst_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  // On contention: the current owner keeps the RAM until its burst saturates;
  // with no owner the port not served last wins.
  always_comb begin
    gnt_a     = iReqA & (!iReqB | (owner_q == OWN_A ? burst_q < MAXB :
                                   owner_q == OWN_B ? burst_q == MAXB : last_b_q));
    gnt_b     = iReqB & !gnt_a;
    owner_d   = gnt_a ? OWN_A : gnt_b ? OWN_B : OWN_NONE;
    burst_d   = !(gnt_a | gnt_b) ? 4'd0 : owner_d != owner_q ? 4'd1 :
                burst_q == MAXB ? MAXB : burst_q + 4'd1;
    last_b_d  = gnt_a ? 1'b0 : gnt_b ? 1'b1 : last_b_q;
    valid_a_d = gnt_a & !iWeA;
    valid_b_d = gnt_b & !iWeB;
  end
  always_comb begin
    oGntA           = gnt_a;
    oGntB           = gnt_b;
    oBusy           = gnt_a | gnt_b;
    oRamWriteEnable = gnt_a ? iWeA : gnt_b ? iWeB : 1'b0;
    oRamAddress     = gnt_a ? iAddrA : gnt_b ? iAddrB : '0;
    oRamDataIn      = gnt_a ? iDataA : gnt_b ? iDataB : '0;
    oValidA         = valid_a_q;
    oValidB         = valid_b_q;
    oDataA          = iRamDataOut;
    oDataB          = iRamDataOut;
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed test of ram_access_arbiter against a rule-level model and a RAM model
module tb_ram_access_arbiter;
  localparam int MB = 4;
  logic       Clock = 1'b0, Reset = 1'b0;
  logic       iReqA, iWeA, iReqB, iWeB;
  logic [9:0] iAddrA, iAddrB;
  logic [7:0] iDataA, iDataB;
  logic       oGntA, oValidA, oGntB, oValidB, oRamWriteEnable, oBusy;
  logic [7:0] oDataA, oDataB, oRamDataIn, ram_q;
  logic [9:0] oRamAddress;
  logic [7:0] ram [1024];
  int         checks = 0, errors = 0;
  int         glog[$];
  int         tie_exp[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
  int         m_own, m_last, m_burst, w, p, ga, gb, i0, n;
  bit         m_va, m_vb, m_ka, m_kb;
  logic [7:0] m_da, m_db;
  logic [7:0] sb [int];

  ram_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_BURST(MB)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReqA(iReqA), .iWeA(iWeA), .iAddrA(iAddrA), .iDataA(iDataA),
    .oGntA(oGntA), .oValidA(oValidA), .oDataA(oDataA),
    .iReqB(iReqB), .iWeB(iWeB), .iAddrB(iAddrB), .iDataB(iDataB),
    .oGntB(oGntB), .oValidB(oValidB), .oDataB(oDataB),
    .oRamWriteEnable(oRamWriteEnable), .oRamAddress(oRamAddress),
    .oRamDataIn(oRamDataIn), .iRamDataOut(ram_q), .oBusy(oBusy));

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (oRamWriteEnable) ram[oRamAddress] <= oRamDataIn;
    ram_q <= ram[oRamAddress];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Rule-level model: decide the winner from requests, owner, burst and last-served.
  always @(negedge Clock) begin
    if (!Reset) begin
      m_own = 0; m_last = 2; m_burst = 0; m_va = 0; m_vb = 0;
    end
    ga = 0; gb = 0;
    if (iReqA && iReqB) begin
      if (m_own == 0) w = (m_last == 1) ? 2 : 1;
      else if (m_burst < MB) w = m_own;
      else w = 3 - m_own;
      ga = int'(w == 1); gb = int'(w == 2);
    end else begin
      ga = int'(iReqA); gb = int'(iReqB);
    end
    chk("gntA", oGntA, ga[0]);
    chk("gntB", oGntB, gb[0]);
    chk("busy", oBusy, ga[0] | gb[0]);
    chk("ram_we", oRamWriteEnable, ga != 0 ? iWeA : gb != 0 ? iWeB : 1'b0);
    chk("ram_addr", oRamAddress, ga != 0 ? iAddrA : gb != 0 ? iAddrB : 10'd0);
    chk("ram_din", oRamDataIn, ga != 0 ? iDataA : gb != 0 ? iDataB : 8'd0);
    chk("validA", oValidA, m_va);
    chk("validB", oValidB, m_vb);
    if (m_va && m_ka) chk("dataA", oDataA, m_da);
    if (m_vb && m_kb) chk("dataB", oDataB, m_db);
    glog.push_back(oGntA ? 1 : oGntB ? 2 : 0);
    if (Reset) begin
      if (ga != 0 || gb != 0) begin
        p = ga != 0 ? 1 : 2;
        m_burst = (m_own == p) ? (m_burst + 1 > MB ? MB : m_burst + 1) : 1;
        m_own = p; m_last = p;
      end else begin
        m_own = 0; m_burst = 0;
      end
      m_va = ga != 0 && !iWeA;
      m_vb = gb != 0 && !iWeB;
      if (m_va) begin m_ka = sb.exists(int'(iAddrA)); m_da = m_ka ? sb[int'(iAddrA)] : 8'd0; end
      if (m_vb) begin m_kb = sb.exists(int'(iAddrB)); m_db = m_kb ? sb[int'(iAddrB)] : 8'd0; end
      if (ga != 0 && iWeA) sb[int'(iAddrA)] = iDataA;
      if (gb != 0 && iWeB) sb[int'(iAddrB)] = iDataB;
    end
  end

  task automatic drv(input logic ra, wa, input logic [9:0] aa, input logic [7:0] da,
                     input logic rb, wb, input logic [9:0] ab, input logic [7:0] db);
    iReqA = ra; iWeA = wa; iAddrA = aa; iDataA = da;
    iReqB = rb; iWeB = wb; iAddrB = ab; iDataB = db;
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge Clock);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_validA", oValidA, 0);
    chk("rst_busy", oBusy, 0);
    @(posedge Clock); #1 Reset = 1'b1;
    // idle
    i0 = glog.size();
    cyc(5);
    n = 0;
    for (int k = i0; k < glog.size(); k++) if (glog[k] != 0) n++;
    chk("idle_grants", n, 0);
    // tie from idle, both reading
    i0 = glog.size();
    drv(1, 0, 10'h012, 0, 1, 0, 10'h020, 0);
    cyc(10);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("tie%0d", k), glog[i0+k], tie_exp[k]);
    cyc(2);
    // single-port write then read
    i0 = glog.size();
    drv(1, 1, 10'h012, 8'h5A, 0, 0, 0, 0);
    cyc(1);
    drv(1, 0, 10'h012, 0, 0, 0, 0, 0);
    @(posedge Clock); #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    chk("wr_gnt", glog[i0], 1);
    chk("rd_gnt", glog[i0+1], 1);
    chk("rd_validA", oValidA, 1);
    chk("rd_dataA", oDataA, 8'h5A);
    chk("rd_validB", oValidB, 0);
    cyc(3);
    // saturation handoff
    i0 = glog.size();
    for (int k = 0; k < 7; k++) begin
      drv(1, 1, 10'h100 + 10'(k), 8'h30 + 8'(k), 0, 0, 0, 0);
      cyc(1);
    end
    drv(1, 1, 10'h107, 8'h37, 1, 0, 10'h101, 0);
    cyc(6);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_a7", glog[i0+6], 1);
    chk("sat_b8", glog[i0+7], 2);
    chk("sat_b11", glog[i0+10], 2);
    chk("sat_a12", glog[i0+11], 1);
    cyc(2);
    // withdrawal
    i0 = glog.size();
    drv(1, 0, 10'h050, 0, 0, 0, 0, 0);
    cyc(2);
    drv(1, 0, 10'h050, 0, 1, 1, 10'h060, 8'hEE);
    @(negedge Clock);
    chk("wd_gntB", oGntB, 0);
    chk("wd_we", oRamWriteEnable, 0);
    @(posedge Clock); #1;
    drv(1, 0, 10'h050, 0, 0, 0, 0, 0);
    cyc(1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(2);
    n = 0;
    for (int k = i0; k < glog.size(); k++) if (glog[k] == 2) n++;
    chk("wd_bgrants", n, 0);
    // reset with a read in flight
    drv(1, 0, 10'h3FF, 0, 0, 0, 0, 0);
    @(negedge Clock);
    chk("mr_gntA", oGntA, 1);
    #1 Reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clock); #1;
    chk("mr_validA0", oValidA, 0);
    @(negedge Clock);
    chk("mr_validA1", oValidA, 0);
    @(posedge Clock); #1 Reset = 1'b1;
    drv(1, 0, 10'h3FF, 0, 1, 0, 10'h012, 0);
    @(negedge Clock);
    chk("mr_tieA", oGntA, 1);
    chk("mr_tieB", oGntB, 0);
    @(posedge Clock); #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
